seg_reader: RTL and testbench
=============================

# seg_reader

Sequential seven-segment readback block: on a start request it scans the six 8-bit HEX display buses one digit at a time, waits for each pattern to be stable, and decodes the active-low segment code back into a 4-bit digit. It is the decode end of the display path that the Project 1 top level drives, so self-checking benches and on-board loopback can recover the displayed date/number as BCD. It sits beside the display top level, with aD0..aD5 tapped in parallel with the HEX pins.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required to accept a digit (range 1..15)
- TIMEOUT, 255: cycles allowed per digit before it is abandoned (range STABLE_CYCLES..255)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a scan; sampled only in IDLE
- aD0..aD5  input  8 each  segment buses, active-low, bit0=a .. bit6=g, bit7=dp
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse, scan complete
- digits  output  24  decoded digits, digits[4i+3:4i] from aDi
- blank  output  6  bit i set when aDi was all segments off
- err  output  6  bit i set when aDi was invalid or timed out
- dp  output  6  decimal-point capture (see Configuration)

## Operation
- Reset: state IDLE; busy, done, digits, blank, err, dp all 0; index and counters 0.
- States: IDLE -> SCAN (start=1 in IDLE) -> SCAN per digit, index 0..5 -> DONE (index 5 accepted) -> IDLE.
- On start acceptance: digits, blank, err, dp cleared to 0; index=0; stable count=0; timeout count=0.
- SCAN, each cycle: compare aD[index][6:0] with held pattern; equal -> stable count+1, else held=current and count=1. Timeout count+1 every cycle.
- Accept when count reaches STABLE_CYCLES: decode held pattern, write nibble, advance index, reset both counters.
- Decode (segments g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blank 1111111 -> nibble 4'hF, blank[i]=1, err[i]=0.
- Any other stable pattern -> nibble 4'hE, err[i]=1.
- Timeout count reaching TIMEOUT before acceptance -> nibble 4'hF, err[i]=1, advance; acceptance and timeout on the same cycle -> acceptance wins.
- start while busy or in DONE is ignored. Outputs hold after DONE until the next accepted start.
- rst_n low at any time (including mid-scan): immediate return to reset values; partial results discarded.

## Timing
- start sampled high at edge 0 -> busy high from edge 1.
- Stable inputs: each digit accepted exactly STABLE_CYCLES edges after its index began; digit i nibble visible after edge (i+1)*STABLE_CYCLES.
- done high for exactly one cycle from edge 6*STABLE_CYCLES+1; busy falls on that same edge. Default: done at edge 25.
- Back-to-back: start may be accepted on the edge after done falls (IDLE), no dead cycles beyond that.
- Worst case: 6*TIMEOUT+1 edges from start to done.
- No combinational path from any input to any output.

## Configuration
- SEG_READER_DP_EN defined: bit7 of the held bus is included in the stability compare and, on acceptance, stored active-high in dp[i] (dp[i]=~aDi[7]). Decode of bits 6:0 is unchanged.
- Not defined: bit7 is ignored entirely; dp tied to 6'b0.

## Test plan
- Reset mid-scan: start, drop rst_n at edge 10 -> busy=0, done=0, digits=0, err=0, blank=0 immediately; no done afterwards.
- Stable date: aD5..aD0 show 0,3,1,5,9,9 (digits 24'h031599), start -> done at edge 25, digits=24'h031599, err=0, blank=0.
- Blank and invalid: aD0=8'hFF, aD1=8'h7F (segment pattern 1111111 with dp lit), aD2=8'h55, rest show 8 -> digits[11:0]=12'hEFF, blank=6'b000011, err=6'b000100.
- Glitch: aD0 toggles between the codes for 1 and 7 every cycle for 6 cycles, then holds the code for 1 -> digit 0 accepted STABLE_CYCLES edges after it settles, nibble 1; done delayed 6 edges versus the stable case.
- Timeout: TIMEOUT=20, aD3 toggles forever -> err=6'b001000, digits[15:12]=4'hF, done at edge 5*4+20+1=41.
- Macro: with SEG_READER_DP_EN, aD2=8'h79 (code for 1 with dp lit) -> dp=6'b000100; without the macro, same stimulus -> dp=0, nibble still 1.

Source files
------------

// File: rtl/seg_reader.sv
// Seven-segment readback: scans aD0..aD5 one digit at a time, waits for a stable
// pattern and decodes it to BCD. Define SEG_READER_DP_EN to capture decimal points.
module seg_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  aD0,
  input  logic [7:0]  aD1,
  input  logic [7:0]  aD2,
  input  logic [7:0]  aD3,
  input  logic [7:0]  aD4,
  input  logic [7:0]  aD5,
  output logic        busy,
  output logic        done,
  output logic [23:0] digits,
  output logic [5:0]  blank,
  output logic [5:0]  err,
  output logic [5:0]  dp
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

`ifdef SEG_READER_DP_EN
  localparam logic [7:0] CMP_MASK = 8'hFF;
`else
  localparam logic [7:0] CMP_MASK = 8'h7F;
`endif

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [7:0]  held_q, held_d;
  logic [23:0] digits_q, digits_d;
  logic [5:0]  blank_q, blank_d;
  logic [5:0]  err_q, err_d;
  logic [5:0]  dp_q, dp_d;
  logic        done_q, done_d;

  logic [7:0]  cur_m;
  logic [3:0]  nib;
  logic        accept, tmo;

  // Segments g..a, active-low; 4'hE marks an unrecognised pattern.
  function automatic logic [3:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = 4'd0;
      7'b1111001: decode = 4'd1;
      7'b0100100: decode = 4'd2;
      7'b0110000: decode = 4'd3;
      7'b0011001: decode = 4'd4;
      7'b0010010: decode = 4'd5;
      7'b0000010: decode = 4'd6;
      7'b1111000: decode = 4'd7;
      7'b0000000: decode = 4'd8;
      7'b0010000: decode = 4'd9;
      7'b1111111: decode = 4'hF;
      default:    decode = 4'hE;
    endcase
  endfunction

  always_comb begin
    case (idx_q)
      3'd0:    cur_m = aD0 & CMP_MASK;
      3'd1:    cur_m = aD1 & CMP_MASK;
      3'd2:    cur_m = aD2 & CMP_MASK;
      3'd3:    cur_m = aD3 & CMP_MASK;
      3'd4:    cur_m = aD4 & CMP_MASK;
      default: cur_m = aD5 & CMP_MASK;
    endcase
  end

  // NOTE: every next-state variable gets its default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    scnt_d   = scnt_q;
    tcnt_d   = tcnt_q;
    held_d   = held_q;
    digits_d = digits_q;
    blank_d  = blank_q;
    err_d    = err_q;
    dp_d     = dp_q;
    done_d   = 1'b0;
    nib      = 4'hF;
    accept   = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SCAN;
          idx_d    = 3'd0;
          scnt_d   = 4'd0;
          tcnt_d   = 8'd0;
          held_d   = 8'd0;
          digits_d = 24'd0;
          blank_d  = 6'd0;
          err_d    = 6'd0;
          dp_d     = 6'd0;
        end
      end
      ST_SCAN: begin
        tcnt_d = tcnt_q + 8'd1;
        // A zero count means this digit has no held pattern yet.
        if (scnt_q != 4'd0 && cur_m == held_q) begin
          scnt_d = scnt_q + 4'd1;
        end else begin
          held_d = cur_m;
          scnt_d = 4'd1;
        end
        accept = (scnt_d == 4'(STABLE_CYCLES));
        tmo    = (tcnt_d == 8'(TIMEOUT));
        if (accept || tmo) begin
          if (accept) begin
            nib                = decode(held_d[6:0]);
            blank_d[idx_q]     = (held_d[6:0] == 7'h7F);
            err_d[idx_q]       = (nib == 4'hE);
`ifdef SEG_READER_DP_EN
            dp_d[idx_q]        = ~held_d[7];
`endif
          end else begin
            err_d[idx_q]       = 1'b1;
          end
          digits_d[{idx_q, 2'b00} +: 4] = nib;
          scnt_d = 4'd0;
          tcnt_d = 8'd0;
          if (idx_q == 3'd5) state_d = ST_DONE;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      scnt_q   <= 4'd0;
      tcnt_q   <= 8'd0;
      held_q   <= 8'd0;
      digits_q <= 24'd0;
      blank_q  <= 6'd0;
      err_q    <= 6'd0;
      dp_q     <= 6'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      scnt_q   <= scnt_d;
      tcnt_q   <= tcnt_d;
      held_q   <= held_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      dp_q     <= dp_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign digits = digits_q;
  assign blank  = blank_q;
  assign err    = err_q;
`ifdef SEG_READER_DP_EN
  assign dp     = dp_q;
`else
  assign dp     = 6'b0;
`endif

endmodule

// File: tb/tb_seg_reader.sv
// Directed bench for seg_reader: a window-based reference model checked every cycle,
// plus literal expectations for done timing and final results.
module tb_seg_reader;
  localparam int S  = 4;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  bus [6];
  logic        busy, done;
  logic [23:0] digits;
  logic [5:0]  blank, err, dp;

  seg_reader #(.STABLE_CYCLES(S), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .aD0(bus[0]), .aD1(bus[1]), .aD2(bus[2]), .aD3(bus[3]), .aD4(bus[4]), .aD5(bus[5]),
    .busy(busy), .done(done), .digits(digits), .blank(blank), .err(err), .dp(dp)
  );

  always #5 clk = ~clk;

`ifdef SEG_READER_DP_EN
  localparam logic [7:0] MASK = 8'hFF;
`else
  localparam logic [7:0] MASK = 8'h7F;
`endif

  // Active-low codes for 0..9, g..a in bits 6..0, dp off.
  logic [7:0] code [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model: a digit is accepted once its last S samples agree,
  // or abandoned when TO samples have been taken without agreement.
  int          m_mode;  // 0 idle, 1 scanning, 2 finishing
  int          m_idx;
  logic [7:0]  hist [$];
  logic        m_busy, m_done;
  logic [23:0] m_digits;
  logic [5:0]  m_blank, m_err, m_dp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; hist.delete();
    m_busy = 0; m_done = 0; m_digits = 0; m_blank = 0; m_err = 0; m_dp = 0;
  endtask

  task automatic model_step();
    logic       acc;
    logic [3:0] n;
    logic [6:0] seg;
    if (!rst_n) begin model_reset(); return; end
    m_done = 0;
    case (m_mode)
      0: if (start) begin
        m_mode = 1; m_busy = 1; m_idx = 0; hist.delete();
        m_digits = 0; m_blank = 0; m_err = 0; m_dp = 0;
      end
      1: begin
        hist.push_back(bus[m_idx] & MASK);
        acc = (hist.size() >= S);
        for (int k = 1; k < S && acc; k++)
          if (hist[hist.size()-1-k] != hist[hist.size()-1]) acc = 0;
        if (acc || hist.size() == TO) begin
          n = 4'hF;
          if (acc) begin
            seg = hist[hist.size()-1][6:0];
            if (seg == 7'h7F) m_blank[m_idx] = 1;
            else begin
              n = 4'hE;
              for (int d = 0; d < 10; d++) if (code[d][6:0] == seg) n = 4'(d);
              if (n == 4'hE) m_err[m_idx] = 1;
            end
`ifdef SEG_READER_DP_EN
            m_dp[m_idx] = ~hist[hist.size()-1][7];
`endif
          end else begin
            m_err[m_idx] = 1;
          end
          m_digits[m_idx*4 +: 4] = n;
          m_idx++;
          hist.delete();
          if (m_idx == 6) m_mode = 2;
        end
      end
      default: begin m_done = 1; m_busy = 0; m_mode = 0; end
    endcase
  endtask

  task automatic compare_all();
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("digits", 32'(digits), 32'(m_digits));
    check("blank", 32'(blank), 32'(m_blank));
    check("err", 32'(err), 32'(m_err));
    check("dp", 32'(dp), 32'(m_dp));
  endtask

  // Inputs are set before calling; the edge samples them, then model and DUT are compared.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    model_step();
    compare_all();
    @(negedge clk);
  endtask

  // Start a scan; returns the edge count from the start edge to done.
  // glitch: aD0 alternates 1/7 for 6 samples; tog3: aD3 alternates forever; hold: start kept high.
  task automatic run_scan(input bit glitch, input bit tog3, input bit hold, output int rel);
    int t0;
    start = 1;
    tick();
    t0  = cyc;
    rel = -1;
    if (!hold) start = 0;
    for (int k = 1; k <= 400 && rel < 0; k++) begin
      if (glitch) bus[0] = (k <= 6 && (k % 2) == 0) ? code[7] : code[1];
      if (tog3)   bus[3] = (k % 2) ? code[8] : code[0];
      tick();
      if (done) rel = cyc - t0;
    end
    start = 0;
    if (rel < 0) check("done_timeout", 32'(rel), 32'(0));
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int i = 0; i < 6; i++) bus[i] = v;
  endtask

  int rel;

  initial begin
    rst_n = 0; start = 0;
    set_all(8'hFF);
    model_reset();
    @(negedge clk);
    tick();
    tick();
    check("reset_digits", 32'(digits), 32'h0);
    rst_n = 1;
    tick();

    // Reset mid-scan: asynchronous clear at edge 10 after start.
    set_all(code[8]);
    start = 1;
    tick();
    start = 0;
    for (int k = 1; k < 10; k++) tick();
    @(posedge clk);
    rst_n = 0;
    cyc++;
    #1;
    model_step();
    compare_all();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_digits", 32'(digits), 32'h0);
    @(negedge clk);
    tick();
    rst_n = 1;
    for (int k = 0; k < 30; k++) tick();

    // Stable date 031599, start held high through the scan (ignored while busy / in DONE).
    {bus[5], bus[4], bus[3], bus[2], bus[1], bus[0]} =
      {code[0], code[3], code[1], code[5], code[9], code[9]};
    run_scan(0, 0, 1, rel);
    check("date_done_edge", 32'(rel), 32'd25);
    check("date_digits", 32'(digits), 32'h031599);
    check("date_err", 32'(err), 32'h0);
    check("date_blank", 32'(blank), 32'h0);
    tick();

    // Blank, blank with dp lit, invalid; started back-to-back.
    set_all(code[8]);
    bus[0] = 8'hFF; bus[1] = 8'h7F; bus[2] = 8'h55;
    run_scan(0, 0, 0, rel);
    check("blk_done_edge", 32'(rel), 32'd25);
    check("blk_digits", 32'(digits), 32'h888EFF);
    check("blk_blank", 32'(blank), 32'b000011);
    check("blk_err", 32'(err), 32'b000100);
    tick();

    // Glitching digit 0 settles on 1 after six alternating samples.
    set_all(code[2]);
    run_scan(1, 0, 0, rel);
    check("glitch_done_edge", 32'(rel), 32'd31);
    check("glitch_digits", 32'(digits), 32'h222221);
    tick();

    // aD3 never settles: abandoned after TO cycles.
    set_all(code[6]);
    run_scan(0, 1, 0, rel);
    check("tmo_done_edge", 32'(rel), 32'd41);
    check("tmo_err", 32'(err), 32'b001000);
    check("tmo_nibble", 32'(digits[15:12]), 32'hF);
    tick();

    // Decimal point on aD2.
    set_all(code[8]);
    bus[2] = 8'h79;
    run_scan(0, 0, 0, rel);
    check("dp_nibble", 32'(digits[11:8]), 32'h1);
`ifdef SEG_READER_DP_EN
    check("dp_bits", 32'(dp), 32'b000100);
`else
    check("dp_bits", 32'(dp), 32'b000000);
`endif
    for (int k = 0; k < 5; k++) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
